eth_rx_framer: RTL and testbench

//  Byte-wide (GMII-style) Ethernet receive front end for the TFTP RX path. Strips

---
 rtl/eth_rx_framer.sv | 164 ++++++++++++++++
 tb/tb_eth_rx_framer.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/eth_rx_framer.sv
// Purpose : GMII byte-stream receive framer; strips preamble/SFD, indexes frame bytes on cnt, flags start/end/errors.
// Latency : 1 cycle from rxd sampled to eth_data/cnt/data_valid; frame_end 1 cycle after rx_dv falls.
// Backpressure: none -- the PHY byte stream cannot be stalled, every body byte is presented once.
//
// Ports: clk, reset (async active-high); rx_dv/rx_er/rxd from PHY;
//        eth_data/cnt/data_valid frame byte stream; frame_start/frame_end pulses;
//        frame_err/fcs_err qualified by frame_end; frame_len held body length incl. FCS.
// Optional feature: define RX_FCS_CHECK_EN to build the CRC32 checker (fcs_err tied 0 otherwise).

module eth_rx_framer #(
    parameter logic [7:0] CNT_BASE     = 8'hFF,
    parameter int         MIN_PREAMBLE = 3,
    parameter int         MIN_LEN      = 60,
    parameter int         MAX_LEN      = 1518
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        rx_dv,
    input  logic        rx_er,
    input  logic [7:0]  rxd,
    output logic [7:0]  eth_data,
    output logic [7:0]  cnt,
    output logic        data_valid,
    output logic        frame_start,
    output logic        frame_end,
    output logic        frame_err,
    output logic        fcs_err,
    output logic [10:0] frame_len
);

    typedef enum logic [1:0] {IDLE, PREAMBLE, BODY, DROP} state_t;

    localparam logic [2:0]  MIN_PRE = 3'(MIN_PREAMBLE);
    localparam logic [10:0] LEN_LO  = 11'(MIN_LEN + 4);
    localparam logic [10:0] LEN_HI  = 11'(MAX_LEN);
    localparam logic [10:0] LEN_SAT = 11'h7FF;
    localparam logic [7:0]  CNT_SAT = 8'hFE;

    state_t      state;
    logic [2:0]  pre_cnt;
    logic [10:0] len;
    logic        err_seen;

`ifdef RX_FCS_CHECK_EN
    // Non-reflected register fed LSB-first per byte; this ordering makes the
    // good-frame residue after data+FCS equal 32'hC704DD7B.
    localparam logic [31:0] CRC_RESIDUE = 32'hC704DD7B;
    logic [31:0] crc;

    function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] d);
        logic [31:0] r;
        r = c;
        for (int i = 0; i < 8; i++) begin
            if (r[31] ^ d[i])
                r = {r[30:0], 1'b0} ^ 32'h04C11DB7;
            else
                r = {r[30:0], 1'b0};
        end
        return r;
    endfunction
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            pre_cnt     <= 3'd0;
            len         <= 11'd0;
            err_seen    <= 1'b0;
            eth_data    <= 8'h00;
            cnt         <= 8'hFF;
            data_valid  <= 1'b0;
            frame_start <= 1'b0;
            frame_end   <= 1'b0;
            frame_err   <= 1'b0;
            fcs_err     <= 1'b0;
            frame_len   <= 11'd0;
`ifdef RX_FCS_CHECK_EN
            crc         <= 32'hFFFFFFFF;
`endif
        end else begin
            // Pulses and per-byte qualifiers default low; cnt parks at FF off-frame.
            frame_start <= 1'b0;
            frame_end   <= 1'b0;
            frame_err   <= 1'b0;
            fcs_err     <= 1'b0;
            data_valid  <= 1'b0;
            cnt         <= 8'hFF;

            case (state)
                IDLE: begin
                    if (rx_dv) begin
                        if (rxd == 8'h55) begin
                            state   <= PREAMBLE;
                            pre_cnt <= 3'd1;
                        end else begin
                            state <= DROP;
                        end
                    end
                end

                PREAMBLE: begin
                    if (!rx_dv) begin
                        state <= IDLE;
                    end else if (rx_er) begin
                        state <= DROP;
                    end else if (rxd == 8'h55) begin
                        if (pre_cnt != 3'd7)
                            pre_cnt <= pre_cnt + 3'd1;
                    end else if (rxd == 8'hD5 && pre_cnt >= MIN_PRE) begin
                        state    <= BODY;
                        len      <= 11'd0;
                        err_seen <= 1'b0;
`ifdef RX_FCS_CHECK_EN
                        crc      <= 32'hFFFFFFFF;
`endif
                    end else begin
                        state <= DROP;
                    end
                end

                BODY: begin
                    if (rx_dv) begin
                        data_valid <= 1'b1;
                        eth_data   <= rxd;
                        // Body bytes are contiguous, so cnt still holds the previous
                        // byte's index here. Once FE is reached it sticks so long
                        // frames never re-enter the header decoders' ranges.
                        if (len == 11'd0) begin
                            cnt         <= CNT_BASE;
                            frame_start <= 1'b1;
                        end else if (cnt == CNT_SAT) begin
                            cnt <= CNT_SAT;
                        end else begin
                            cnt <= cnt + 8'd1;
                        end
                        if (len != LEN_SAT)
                            len <= len + 11'd1;
                        if (rx_er)
                            err_seen <= 1'b1;
`ifdef RX_FCS_CHECK_EN
                        crc <= crc_byte(crc, rxd);
`endif
                    end else begin
                        frame_end <= 1'b1;
                        frame_len <= len;
                        frame_err <= err_seen || (len < LEN_LO) || (len > LEN_HI);
`ifdef RX_FCS_CHECK_EN
                        fcs_err   <= (crc != CRC_RESIDUE);
`endif
                        state     <= IDLE;
                    end
                end

                DROP: begin
                    if (!rx_dv)
                        state <= IDLE;
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_eth_rx_framer.sv
// Purpose : randomized bench for eth_rx_framer against a frame-level reference model.
// Latency : model expects bytes one cycle after drive and frame_end one cycle after rx_dv drop.
// Backpressure: none; the bench drives a continuous PHY stream.

module tb_eth_rx_framer;

    localparam logic [7:0] CNT_BASE = 8'hFF;
    localparam int         MIN_PRE  = 3;
    localparam int         MIN_LEN  = 60;
    localparam int         MAX_LEN  = 1518;

    logic        clk = 1'b0;
    logic        reset;
    logic        rx_dv;
    logic        rx_er;
    logic [7:0]  rxd;
    logic [7:0]  eth_data;
    logic [7:0]  cnt;
    logic        data_valid;
    logic        frame_start;
    logic        frame_end;
    logic        frame_err;
    logic        fcs_err;
    logic [10:0] frame_len;

    eth_rx_framer #(
        .CNT_BASE(CNT_BASE), .MIN_PREAMBLE(MIN_PRE), .MIN_LEN(MIN_LEN), .MAX_LEN(MAX_LEN)
    ) dut (
        .clk(clk), .reset(reset), .rx_dv(rx_dv), .rx_er(rx_er), .rxd(rxd),
        .eth_data(eth_data), .cnt(cnt), .data_valid(data_valid),
        .frame_start(frame_start), .frame_end(frame_end), .frame_err(frame_err),
        .fcs_err(fcs_err), .frame_len(frame_len)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    typedef struct {
        int len;
        bit err;
        bit fcs;
        int cyc;
    } end_t;

    // byte word = {frame_start, cnt, eth_data}
    logic [16:0] exp_byte[$];
    logic [16:0] obs_byte[$];
    end_t        exp_end[$];
    end_t        obs_end[$];
    logic [7:0]  frm[$];
    int          cyc   = 0;
    int          stray = 0;
    end_t        mon_e;

    // Monitor: samples 1 time unit after each rising edge.
    initial begin
        forever begin
            @(posedge clk);
            cyc++;
            #1;
            if (data_valid === 1'b1) begin
                obs_byte.push_back({frame_start, cnt, eth_data});
            end else begin
                if (cnt !== 8'hFF) stray++;
                if (frame_start !== 1'b0) stray++;
            end
            if (frame_end === 1'b1) begin
                mon_e.len = int'(frame_len);
                mon_e.err = frame_err;
                mon_e.fcs = fcs_err;
                mon_e.cyc = cyc;
                obs_end.push_back(mon_e);
            end else if (frame_err !== 1'b0 || fcs_err !== 1'b0) begin
                stray++;
            end
        end
    end

    // Standard reflected Ethernet CRC over the first n bytes of frm.
    function automatic logic [31:0] ref_crc(input int n);
        logic [31:0] c;
        c = 32'hFFFFFFFF;
        for (int i = 0; i < n; i++) begin
            c = c ^ {24'h0, frm[i]};
            for (int b = 0; b < 8; b++)
                c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
        end
        return ~c;
    endfunction

    // Index n counts up from CNT_BASE modulo 256 until it first reaches FE, then stays there.
    function automatic logic [7:0] model_cnt(input int n);
        int n0;
        n0 = (254 - int'(CNT_BASE)) & 255;
        if (n < n0) return 8'((int'(CNT_BASE) + n) & 255);
        return 8'hFE;
    endfunction

    task automatic build_frame(input int len, input bit corrupt);
        logic [31:0] c;
        frm.delete();
        if (len < 4) begin
            for (int i = 0; i < len; i++) frm.push_back(8'($urandom));
        end else begin
            for (int i = 0; i < len - 4; i++) frm.push_back(8'($urandom));
            c = ref_crc(len - 4);
            for (int i = 0; i < 4; i++) frm.push_back(c[8*i +: 8]);
            if (corrupt) frm[len-1] = frm[len-1] ^ 8'h01;
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            rx_dv = 1'b0;
            rx_er = 1'b0;
            rxd   = 8'($urandom);
        end
    endtask

    task automatic send_frame(input int npre, input logic [7:0] sfd, input bit pre_er, input int er_pos);
        int          len;
        int          drop;
        bit          acc;
        end_t        e;
        logic [31:0] rx_fcs;
        len = frm.size();
        for (int i = 0; i < npre; i++) begin
            @(negedge clk);
            rx_dv = 1'b1;
            rx_er = pre_er && (i == npre - 1);
            rxd   = 8'h55;
        end
        @(negedge clk);
        rx_dv = 1'b1;
        rx_er = 1'b0;
        rxd   = sfd;
        for (int n = 0; n < len; n++) begin
            @(negedge clk);
            rxd   = frm[n];
            rx_er = (n == er_pos);
        end
        @(negedge clk);
        rx_dv = 1'b0;
        rx_er = 1'b0;
        drop  = cyc;

        acc = (npre >= MIN_PRE) && (sfd == 8'hD5) && !pre_er;
        if (acc) begin
            for (int n = 0; n < len; n++)
                exp_byte.push_back({(n == 0), model_cnt(n), frm[n]});
            e.len = (len > 2047) ? 2047 : len;
            e.err = (er_pos >= 0 && er_pos < len) || (len < MIN_LEN + 4) || (len > MAX_LEN);
`ifdef RX_FCS_CHECK_EN
            if (len >= 4) begin
                rx_fcs = {frm[len-1], frm[len-2], frm[len-3], frm[len-4]};
                e.fcs  = (ref_crc(len - 4) != rx_fcs);
            end else begin
                e.fcs = 1'b1;
            end
`else
            rx_fcs = 32'h0;
            e.fcs  = 1'b0;
`endif
            e.cyc = drop + 1;
            exp_end.push_back(e);
        end
    endtask

    task automatic drain(input string tag);
        end_t eo;
        end_t ee;
        chk({tag, " nbytes"}, obs_byte.size(), exp_byte.size());
        while (obs_byte.size() > 0 && exp_byte.size() > 0)
            chk({tag, " byte"}, {15'h0, obs_byte.pop_front()}, {15'h0, exp_byte.pop_front()});
        chk({tag, " nends"}, obs_end.size(), exp_end.size());
        while (obs_end.size() > 0 && exp_end.size() > 0) begin
            eo = obs_end.pop_front();
            ee = exp_end.pop_front();
            chk({tag, " frame_len"}, eo.len, ee.len);
            chk({tag, " frame_err"}, {31'h0, eo.err}, {31'h0, ee.err});
            chk({tag, " fcs_err"}, {31'h0, eo.fcs}, {31'h0, ee.fcs});
            chk({tag, " end_cycle"}, eo.cyc, ee.cyc);
        end
        chk({tag, " stray"}, stray, 0);
        stray = 0;
        obs_byte.delete();
        exp_byte.delete();
        obs_end.delete();
        exp_end.delete();
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, " cnt"}, {24'h0, cnt}, 32'hFF);
        chk({tag, " eth_data"}, {24'h0, eth_data}, 32'h0);
        chk({tag, " frame_len"}, {21'h0, frame_len}, 32'h0);
        chk({tag, " flags"}, {27'h0, data_valid, frame_start, frame_end, frame_err, fcs_err}, 32'h0);
    endtask

    initial begin
        int len;
        int npre;
        int er_pos;
        reset = 1'b1;
        rx_dv = 1'b0;
        rx_er = 1'b0;
        rxd   = 8'h00;
        repeat (3) @(negedge clk);
        check_reset_outputs("in_reset");
        reset = 1'b0;

        // Idle after reset
        idle(100);
        check_reset_outputs("idle100");
        drain("idle");

        // Good 64-byte frame with long preamble
        build_frame(64, 1'b0);
        send_frame(7, 8'hD5, 1'b0, -1);
        idle(3);
        chk("udp64 byte34 cnt", (obs_byte.size() > 34) ? {23'h0, obs_byte[34][15:8]} : 32'hDEAD, 32'h21);
        drain("udp64");

        // Same frame shape, last FCS byte flipped
        build_frame(64, 1'b1);
        send_frame(7, 8'hD5, 1'b0, -1);
        idle(3);
        drain("badfcs");

        // Short preamble, bad SFD, rx_er in preamble: all dropped
        build_frame(64, 1'b0);
        send_frame(2, 8'hD5, 1'b0, -1);
        idle(2);
        send_frame(7, 8'h5D, 1'b0, -1);
        idle(2);
        send_frame(5, 8'hD5, 1'b1, -1);
        idle(3);
        drain("dropped");

        // rx_er in body, runt frame, empty body, minimum preamble back-to-back
        build_frame(64, 1'b0);
        send_frame(7, 8'hD5, 1'b0, 20);
        build_frame(40, 1'b0);
        send_frame(3, 8'hD5, 1'b0, -1);
        frm.delete();
        send_frame(7, 8'hD5, 1'b0, -1);
        idle(3);
        drain("errs");

        // Randomized frames, gaps down to a single rx_dv-low cycle
        for (int f = 0; f < 24; f++) begin
            len    = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 70) : $urandom_range(60, 300);
            npre   = $urandom_range(1, 8);
            er_pos = ($urandom_range(0, 4) == 0) ? $urandom_range(0, 80) : -1;
            build_frame(len, $urandom_range(0, 3) == 0);
            send_frame(npre, 8'hD5, 1'b0, er_pos);
            idle($urandom_range(0, 2));
        end
        idle(3);
        drain("random");

        // Oversized frame: cnt sticks at FE
        build_frame(1600, 1'b0);
        send_frame(7, 8'hD5, 1'b0, -1);
        idle(3);
        chk("big last cnt", (obs_byte.size() == 1600) ? {23'h0, obs_byte[1599][15:8]} : 32'hDEAD, 32'hFE);
        drain("big");

        // Reset asserted while body byte 10 is on the wire
        build_frame(100, 1'b0);
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            rx_dv = 1'b1;
            rxd   = 8'h55;
        end
        @(negedge clk);
        rxd = 8'hD5;
        for (int n = 0; n < 10; n++) begin
            @(negedge clk);
            rxd = frm[n];
            exp_byte.push_back({(n == 0), model_cnt(n), frm[n]});
        end
        @(negedge clk);
        rxd   = frm[10];
        reset = 1'b1;
        #1;
        check_reset_outputs("abort");
        @(negedge clk);
        rx_dv = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        idle(5);
        drain("abort");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
